read_selector: RTL and testbench
================================

Name: read_selector

Overview:
- Read-agent front end of the multi-port RAM; the consumer of the write-ownership select that the write-side bookkeeping produces.
- Accepts read requests over a valid/ready handshake and issues the read to every write-agent memory bank and to the ownership table.
- Realigns the returned select with the bank data, multiplexes the correct bank, and buffers responses so downstream backpressure never drops a read.

Parameters:
ADDR_WIDTH, 8, read address width
DATA_WIDTH, 32, word width of each bank
NB_WRAGENT, 2, number of write agents / memory banks
SELECT_WIDTH, $clog2(NB_WRAGENT), width of the ownership select
RD_LATENCY, 2, cycles from rden to valid bank data and rdselect (>=1)
FIFO_DEPTH, 4, response buffer entries; must be >= RD_LATENCY+2, power of two

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
req_valid  in  1  read request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  ADDR_WIDTH  read address
rden  out  1  read enable to banks and ownership table
rdaddr  out  ADDR_WIDTH  read address to banks and ownership table
rdselect  in  SELECT_WIDTH  owning write agent, valid RD_LATENCY cycles after rden
bank_rddata  in  NB_WRAGENT*DATA_WIDTH  concatenated bank outputs, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when rsp_valid & rsp_ready
rsp_data  out  DATA_WIDTH  selected read data
rsp_agent  out  SELECT_WIDTH  rdselect captured with the data

Behaviour:
- Reset (async assert, sync release): pipeline valid bits, FIFO pointers and count cleared. req_ready=0 while aresetn low, 1 on the first cycle after release. rsp_valid=0, rsp_data=0, rsp_agent=0.
- Reset mid-operation discards all in-flight reads and buffered responses. No response is produced for any of them.
- Credit rule: req_ready = (inflight + fifo_count) < FIFO_DEPTH. inflight is the number of set bits in the RD_LATENCY-deep valid shift register. req_ready does not depend on rsp_ready combinationally.
- Issue: rden = req_valid & req_ready, combinational. rdaddr = req_addr whenever rden=1, otherwise holds its last value.
- Pipeline: the valid bit enters stage 0 on the accepted cycle T. At cycle T+RD_LATENCY, when the last-stage bit is set, rdselect and the bank word it indexes are written to the FIFO. The data mux uses the rdselect value at the capture cycle.
- Latency: request accepted at T gives rsp_valid high at T+RD_LATENCY+1 when the FIFO was empty.
- Throughput: one response per cycle with req_valid and rsp_ready held high (guaranteed by FIFO_DEPTH >= RD_LATENCY+2).
- FIFO: first-in first-out, pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
- Overflow cannot occur because of the credit rule. Pop only when rsp_valid & rsp_ready.
- rsp_valid = fifo_count != 0.
- rsp_data and rsp_agent show the head entry and stay stable while rsp_valid & !rsp_ready.
- rdselect >= NB_WRAGENT (non-power-of-two agent counts): data taken from bank 0.
- Response order always equals request order.

Optional Feature:
- Macro: READ_SELECTOR_SELCHECK_EN.
- When defined:
  - Adds output rsp_err (1 bit, FIFO-aligned with rsp_data, reset 0).
  - rdselect >= NB_WRAGENT at capture stores rsp_err=1 and rsp_data=0.
- When undefined:
  - No rsp_err port.
  - Out-of-range select returns bank 0 data as above.

Test Plan:
- Single read: NB_WRAGENT=2, bank1 holds 0xCAFE0001 at addr 0x10, rdselect=1. Accept at T -> rden=1, rdaddr=0x10 at T; rsp_valid at T+3, rsp_data=0xCAFE0001, rsp_agent=1.
- Streaming: 16 back-to-back requests, addresses 0..15, rdselect alternating 0/1, rsp_ready=1 -> req_ready never drops; 16 responses on consecutive cycles in address order with correct bank data.
- Backpressure: rsp_ready=0, requests continuously valid -> exactly 4 requests accepted, then req_ready=0. Raising rsp_ready drains 4 responses in order, and req_ready returns to 1 the cycle after the first pop.
- Head stability: rsp_ready toggled 1/0 every cycle over 8 reads -> rsp_data and rsp_agent are unchanged during every stalled cycle; no loss and no duplicate.
- Reset mid-flight: 3 reads accepted, aresetn pulsed low before any response -> rsp_valid=0 and outputs 0 immediately; no stale response after release; a new read returns correct data.
- SELCHECK (macro defined, NB_WRAGENT=3): rdselect=3 -> rsp_err=1, rsp_data=0. rdselect=2 -> rsp_err=0 with bank2 data.

Source files
------------

// File: rtl/read_selector.sv
// read_selector: read-agent front end of the multi-port RAM.
// Issues each accepted read to all banks and the ownership table, realigns the
// returned select with the bank data, picks the owning bank and buffers the
// result in a small FIFO so that downstream backpressure never drops a read.
// Optional feature macro: READ_SELECTOR_SELCHECK_EN (adds rsp_err and zeroes
// the data of reads whose select is out of range).
module read_selector #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_WRAGENT   = 2,
  parameter int unsigned SELECT_WIDTH = $clog2(NB_WRAGENT),
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             rden,
  output logic [ADDR_WIDTH-1:0]            rdaddr,
  input  logic [SELECT_WIDTH-1:0]          rdselect,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
`ifdef READ_SELECTOR_SELCHECK_EN
  output logic                             rsp_err,
`endif
  output logic [SELECT_WIDTH-1:0]          rsp_agent
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_mem_q  [FIFO_DEPTH];
  logic [SELECT_WIDTH-1:0] agent_mem_q [FIFO_DEPTH];
`ifdef READ_SELECTOR_SELCHECK_EN
  logic                    err_mem_q   [FIFO_DEPTH];
  logic                    cap_ok;
`endif

  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [CRED_W-1:0]       credit_d;

  assign req_ready = ready_q;
  assign rden      = req_valid & ready_q;
  assign rdaddr    = rden ? req_addr : addr_q;
  assign rsp_valid = (cnt_q != '0);
  assign rsp_data  = data_mem_q[rd_ptr_q];
  assign rsp_agent = agent_mem_q[rd_ptr_q];
`ifdef READ_SELECTOR_SELCHECK_EN
  assign rsp_err   = err_mem_q[rd_ptr_q];
`endif

  // Bank mux driven by the select returned alongside the data; unknown owners fall back to bank 0
  always_comb begin
    cap_data = bank_rddata[DATA_WIDTH-1:0];
`ifdef READ_SELECTOR_SELCHECK_EN
    cap_ok   = 1'b0;
`endif
    for (int unsigned i = 0; i < NB_WRAGENT; i++) begin
      if (rdselect == SELECT_WIDTH'(i)) begin
        cap_data = bank_rddata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef READ_SELECTOR_SELCHECK_EN
        cap_ok   = 1'b1;
`endif
      end
    end
`ifdef READ_SELECTOR_SELCHECK_EN
    if (!cap_ok) begin
      cap_data = '0;
    end
`endif
  end

  // Next state for the latency pipeline, FIFO pointers and the request credit
  always_comb begin
    push     = vld_q[RD_LATENCY-1];
    pop      = rsp_valid & rsp_ready;
    vld_d    = (vld_q << 1) | RD_LATENCY'(rden);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    credit_d = CRED_W'(cnt_d);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      credit_d = credit_d + CRED_W'(vld_d[i]);
    end
    ready_d  = (credit_d < CRED_W'(FIFO_DEPTH));
  end

  // Control registers; reset drops every in-flight and buffered read
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      addr_q   <= rdaddr;
    end
  end

  // Response storage; cleared on reset so the head reads as zero
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i]  <= '0;
        agent_mem_q[i] <= '0;
`ifdef READ_SELECTOR_SELCHECK_EN
        err_mem_q[i]   <= 1'b0;
`endif
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q]  <= cap_data;
      agent_mem_q[wr_ptr_q] <= rdselect;
`ifdef READ_SELECTOR_SELCHECK_EN
      err_mem_q[wr_ptr_q]   <= !cap_ok;
`endif
    end
  end

endmodule

// File: tb/tb_read_selector.sv
// Testbench for read_selector: RAM/ownership model with fixed latency, and a
// queue-based reference of outstanding reads checked every cycle.
module tb_read_selector;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = 3;
  localparam int unsigned SW    = 2;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic              aclk;
  logic              aresetn;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic              rden;
  logic [AW-1:0]     rdaddr;
  logic [SW-1:0]     rdselect;
  logic [NB*DW-1:0]  bank_rddata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [SW-1:0]     rsp_agent;
`ifdef READ_SELECTOR_SELCHECK_EN
  logic              rsp_err;
`endif

  read_selector #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(NB), .SELECT_WIDTH(SW),
    .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rden(rden), .rdaddr(rdaddr), .rdselect(rdselect), .bank_rddata(bank_rddata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef READ_SELECTOR_SELCHECK_EN
    .rsp_err(rsp_err),
`endif
    .rsp_agent(rsp_agent)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // RAM contents and ownership table
  logic [DW-1:0] mem [NB][256];
  logic [SW-1:0] own [256];
  logic [AW-1:0] pa  [LAT];

  // Fixed-latency RAM: address issued at T yields data/select during T+LAT
  always @(posedge aclk) begin
    pa[0] <= rden ? rdaddr : AW'($urandom);
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end

  always_comb begin
    bank_rddata = '0;
    for (int b = 0; b < NB; b++) bank_rddata[b*DW +: DW] = mem[b][pa[LAT-1]];
    rdselect = own[pa[LAT-1]];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] agent;
    logic          err;
    int            t;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            armed = 0;
  logic [AW-1:0] last_addr = '0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_agent;
  int            dut_acc = 0;
  int            pops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] a, input int t);
    exp_t e;
    logic [SW-1:0] sel;
    sel     = own[a];
    e.agent = sel;
    e.t     = t;
    e.err   = 1'b0;
    if (int'(sel) < int'(NB)) begin
      e.data = mem[sel][a];
    end else begin
`ifdef READ_SELECTOR_SELCHECK_EN
      e.data = '0;
      e.err  = 1'b1;
`else
      e.data = mem[0][a];
`endif
    end
    return e;
  endfunction

  // Mid-cycle checks against the reference, then model update
  task automatic check_half();
    bit exp_ready, acc, exp_valid;
    @(negedge aclk);
    exp_ready = aresetn && armed && (q.size() < DEPTH);
    acc       = req_valid && exp_ready;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rden", 64'(rden), 64'(acc));
    if (rden) dut_acc++;
    if (acc) chk("rdaddr", 64'(rdaddr), 64'(req_addr));
    else     chk("rdaddr_hold", 64'(rdaddr), 64'(last_addr));
    exp_valid = aresetn && (q.size() > 0) && (cyc >= q[0].t + LAT + 1);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
      chk("rsp_agent", 64'(rsp_agent), 64'(q[0].agent));
`ifdef READ_SELECTOR_SELCHECK_EN
      chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
`endif
    end
    if (prev_stall) begin
      chk("hold_data", 64'(rsp_data), 64'(prev_data));
      chk("hold_agent", 64'(rsp_agent), 64'(prev_agent));
    end
    prev_stall = exp_valid && !rsp_ready;
    prev_data  = rsp_data;
    prev_agent = rsp_agent;
    if (exp_valid && rsp_ready) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) begin
      q.push_back(model(req_addr, cyc));
      last_addr = req_addr;
    end
  endtask

  task automatic adv();
    @(posedge aclk);
    cyc++;
    if (aresetn) armed = 1;
    #1;
  endtask

  task automatic step();
    check_half();
    adv();
  endtask

  task automatic reset_model();
    q.delete();
    armed      = 0;
    last_addr  = '0;
    prev_stall = 0;
  endtask

  int a0, p0, sent;
  logic [DW-1:0] exp_d;

  initial begin
    aresetn   = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < NB; b++) mem[b][a] = $urandom;
      own[a] = SW'($urandom_range(0, NB - 1));
    end
    for (int a = 8'h80; a < 8'h90; a++) own[a] = SW'(3);
    for (int a = 0; a < 16; a++) own[a] = SW'(a % 2);
    mem[1][8'h10] = 32'hCAFE0001;
    own[8'h10]    = SW'(1);
    own[8'h20]    = SW'(3);
    own[8'h21]    = SW'(2);
    mem[2][8'h21] = 32'h22220021;
    for (int i = 0; i < LAT; i++) pa[i] = '0;

    // Power-on reset
    #2 aresetn = 1'b0;
    #1;
    reset_model();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_agent", 64'(rsp_agent), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    step(); step();
    aresetn = 1'b1;
    step();
    chk("ready_after_release", 64'(req_ready), 64'd1);

    // Single read
    req_valid = 1'b1; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_data", 64'(rsp_data), 64'hCAFE0001);
    chk("single_agent", 64'(rsp_agent), 64'd1);
    step();

    // Streaming 16 back-to-back reads
    a0 = dut_acc; p0 = pops;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = AW'(i);
      step();
    end
    req_valid = 1'b0;
    chk("stream_accepts", 64'(dut_acc - a0), 64'd16);
    for (int i = 0; i < 4; i++) step();
    chk("stream_pops", 64'(pops - p0), 64'd16);

    // Backpressure
    rsp_ready = 1'b0;
    a0 = dut_acc;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = AW'($urandom);
      step();
    end
    chk("bp_accepts", 64'(dut_acc - a0), 64'd4);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    req_valid = 1'b0; rsp_ready = 1'b1; p0 = pops;
    for (int i = 0; i < 6; i++) step();
    chk("bp_drained", 64'(pops - p0), 64'd4);

    // Head stability with rsp_ready toggling
    a0 = dut_acc; p0 = pops;
    for (int i = 0; i < 24; i++) begin
      sent      = dut_acc - a0;
      req_valid = (sent < 8);
      req_addr  = AW'($urandom);
      rsp_ready = i[0];
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("toggle_accepts", 64'(dut_acc - a0), 64'd8);
    chk("toggle_pops", 64'(pops - p0), 64'd8);

    // Reset while three reads are in flight
    req_valid = 1'b1; req_addr = 8'h05; step();
    req_addr = 8'h06; step();
    req_addr = 8'h07; check_half();
    #1 aresetn = 1'b0;
    #1;
    reset_model();
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_data", 64'(rsp_data), 64'd0);
    chk("mid_rst_agent", 64'(rsp_agent), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    adv();
    req_valid = 1'b0;
    step(); step();
    aresetn = 1'b1;
    p0 = pops;
    for (int i = 0; i < 6; i++) step();
    chk("no_stale_rsp", 64'(pops - p0), 64'd0);

    // In-range and out-of-range selects
    req_valid = 1'b1; req_addr = 8'h21;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("sel2_valid", 64'(rsp_valid), 64'd1);
    chk("sel2_data", 64'(rsp_data), 64'h22220021);
    chk("sel2_agent", 64'(rsp_agent), 64'd2);
`ifdef READ_SELECTOR_SELCHECK_EN
    chk("sel2_err", 64'(rsp_err), 64'd0);
`endif
    step();
    req_valid = 1'b1; req_addr = 8'h20;
    step();
    req_valid = 1'b0;
    step(); step();
`ifdef READ_SELECTOR_SELCHECK_EN
    exp_d = '0;
    chk("sel3_err", 64'(rsp_err), 64'd1);
`else
    exp_d = mem[0][8'h20];
`endif
    chk("sel3_valid", 64'(rsp_valid), 64'd1);
    chk("sel3_data", 64'(rsp_data), 64'(exp_d));
    chk("sel3_agent", 64'(rsp_agent), 64'd3);
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
